// File: rtl/axi_stream_reader_pkg.sv
// Shared definitions for the AXI-Lite stream reader: controller state
// encoding and AXI response codes.
package axi_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_stream_reader_if.sv
// Bundles the AXI-Lite read channels and the output stream of the reader.
// The master modport is the reader's view; slave is the memory/consumer side.
interface axi_stream_reader_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] axi_araddr;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output axi_araddr, axi_arvalid, axi_rready, out_data, out_valid,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid, out_ready
  );

  modport slave (
    input  axi_araddr, axi_arvalid, axi_rready, out_data, out_valid,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid, out_ready
  );

endinterface

// File: rtl/axi_stream_reader_sync_fifo.sv
// Small synchronous FIFO buffering returned read data for the output stream.
// The head word is presented combinationally; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic [ADDR_SIZE:0]    count_o
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE:0]    wptr_q;
  logic [ADDR_SIZE:0]    rptr_q;
  logic                  full;
  logic                  wrEn;
  logic                  rdEn;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == (ADDR_SIZE + 1)'(DEPTH));
  assign rdEn    = pop_i & ~empty_o;
  assign wrEn    = push_i & (~full | rdEn);
  assign data_o  = mem_q[rptr_q[ADDR_SIZE-1:0]];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wptr_q[ADDR_SIZE-1:0]] <= data_i;
    end
  end

  // Read and write pointers carry one extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wrEn) wptr_q <= wptr_q + 1'b1;
      if (rdEn) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_reader.sv
// AXI-Lite burst reader: issues sequential word reads starting at a base
// address, never committing more reads than the output FIFO can absorb,
// and streams the returned words out in order.
module axi_stream_reader
  import axi_stream_reader_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [AXI_ADDR_WIDTH:0]   len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  axi_stream_reader_if.master       bus
);

  localparam int AS = $clog2(FIFO_DEPTH);
  localparam int CW = AS + 1;
  localparam logic [CW+1:0] DEPTH_LIMIT = (CW + 2)'(FIFO_DEPTH);

  state_e                    state_q,    state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [AXI_ADDR_WIDTH:0]   len_q,      len_d;
  logic [AXI_ADDR_WIDTH:0]   issued_q,   issued_d;
  logic [AXI_ADDR_WIDTH:0]   received_q, received_d;
  logic [CW-1:0]             inflight_q, inflight_d;
  logic                      arvalid_q,  arvalid_d;
  logic                      rready_q,   rready_d;
  logic                      err_q,      err_d;
  logic                      done_q,     done_d;
  logic                      busy_q,     busy_d;

  logic                      arHs;
  logic                      rHs;
  logic                      fifoPop;
  logic                      fifoEmpty;
  logic [CW-1:0]             fifoCount;
  logic [AXI_DATA_WIDTH-1:0] fifoData;
  logic [CW:0]               occNext;
  logic [CW+1:0]             creditUsed;

  assign arHs    = arvalid_q & bus.axi_arready;
  assign rHs     = rready_q & bus.axi_rvalid;
  assign fifoPop = ~fifoEmpty & bus.out_ready;
  assign occNext = {1'b0, fifoCount} + {{CW{1'b0}}, rHs} - {{CW{1'b0}}, fifoPop};

  assign bus.axi_araddr  = addr_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_rready  = rready_q;
  assign bus.out_valid   = ~fifoEmpty;
  assign bus.out_data    = fifoData;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

  sync_fifo #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .ADDR_SIZE  (AS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rHs),
    .data_i  (bus.axi_rdata),
    .pop_i   (fifoPop),
    .data_o  (fifoData),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Next-state logic: burst sequencing, counters, and the credit check that
  // decides whether another read address may be offered next cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    err_d      = err_q;
    inflight_d = inflight_q + CW'(arHs) - CW'(rHs);

    if (rHs) begin
      received_d = received_q + 1'b1;
      if (bus.axi_rresp != RESP_OKAY) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d     = base_addr_i;
          len_d      = len_i;
          issued_d   = '0;
          received_d = '0;
          err_d      = 1'b0;
          state_d    = (len_i != '0) ? ST_ADDR : ST_DONE;
        end
      end
      ST_ADDR: begin
        if (arHs) begin
          addr_d   = addr_q + 1'b1;
          issued_d = issued_q + 1'b1;
          if (issued_q + 1'b1 == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rHs && (received_q + 1'b1 == len_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    creditUsed = {1'b0, occNext} + {2'b00, inflight_d};
    if (arvalid_q && !bus.axi_arready) begin
      arvalid_d = 1'b1;
    end else begin
      arvalid_d = (state_d == ST_ADDR) && (issued_d < len_d) &&
                  (creditUsed < DEPTH_LIMIT);
    end

    rready_d = (state_d == ST_ADDR) || (state_d == ST_DRAIN);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // Controller registers; every externally visible control output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      inflight_q <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      inflight_q <= inflight_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_reader.sv
// Testbench for axi_stream_reader: a randomised AXI-Lite memory responder and
// stream consumer, with expected addresses and data derived from the burst
// parameters alone.
module tb_axi_stream_reader;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int passes = 0;

  // Responder / consumer behaviour knobs
  int arReadyPct  = 100;
  int outReadyPct = 100;
  int latMin      = 1;
  int latMax      = 1;
  int errBeat     = -1;
  bit flushResp   = 1'b0;

  // Observations
  int            cycle = 0;
  int            beatIdx = 0;
  int            arCount = 0;
  int            doneCount = 0;
  bit            errAtDone = 1'b0;
  logic [AW-1:0] pendAddr[$];
  int            pendDue[$];
  logic [AW-1:0] arObs[$];
  logic [DW-1:0] outObs[$];
  int            outCyc[$];

  axi_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_stream_reader #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .base_addr_i (baseAddr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the reader
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return a[15:0] ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ 16'hA5C3;
  endfunction

  // Reference: word i of a burst lives at (base + i) mod 2^AW
  function automatic logic [AW-1:0] modelAddr(input logic [AW-1:0] base, input int i);
    return AW'((int'(base) + i) % (1 << AW));
  endfunction

  // Memory responder and consumer: observe handshakes on the falling edge,
  // drive the next values just after the rising edge.
  initial begin
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = '0;
    bus.axi_rresp   = 2'b00;
    bus.out_ready   = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!reset) begin
        if (bus.axi_arvalid && bus.axi_arready) begin
          arObs.push_back(bus.axi_araddr);
          arCount++;
          pendAddr.push_back(bus.axi_araddr);
          pendDue.push_back(cycle + int'($urandom_range(latMax, latMin)) - 1);
        end
        if (bus.axi_rvalid && bus.axi_rready) begin
          void'(pendAddr.pop_front());
          void'(pendDue.pop_front());
          beatIdx++;
        end
        if (bus.out_valid && bus.out_ready) begin
          outObs.push_back(bus.out_data);
          outCyc.push_back(cycle);
        end
        if (done) begin
          doneCount++;
          errAtDone = err;
        end
      end
      @(posedge clk);
      #1;
      if (flushResp) begin
        pendAddr.delete();
        pendDue.delete();
        flushResp = 1'b0;
      end
      bus.axi_arready = (int'($urandom_range(99, 0)) < arReadyPct);
      bus.out_ready   = (int'($urandom_range(99, 0)) < outReadyPct);
      if (pendAddr.size() > 0 && pendDue[0] <= cycle) begin
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = memWord(pendAddr[0]);
        bus.axi_rresp  = (beatIdx == errBeat) ? 2'b10 : 2'b00;
      end else begin
        bus.axi_rvalid = 1'b0;
        bus.axi_rdata  = '0;
        bus.axi_rresp  = 2'b00;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearObs();
    arObs.delete();
    outObs.delete();
    outCyc.delete();
    arCount   = 0;
    doneCount = 0;
    beatIdx   = 0;
    errAtDone = 1'b0;
  endtask

  task automatic startBurst(input logic [AW-1:0] b, input int n);
    clearObs();
    @(posedge clk);
    #1;
    start    = 1'b1;
    baseAddr = b;
    len      = (AW + 1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitBurst(input int n, input int maxCycles, output bit timedOut);
    int k = 0;
    while ((doneCount == 0 || outObs.size() < n) && k < maxCycles) begin
      @(negedge clk);
      #1;
      k++;
    end
    timedOut = (k >= maxCycles);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    baseAddr = '0;
    len = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passes++;
    checks++; if (bus.axi_arvalid !== 1'b0) $display("[TB] FAIL reset_arvalid: got %b expected 0", bus.axi_arvalid); else passes++;
    checks++; if (bus.axi_rready !== 1'b0) $display("[TB] FAIL reset_rready: got %b expected 0", bus.axi_rready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passes++;
  endtask

  task automatic test_basic();
    bit to;
    arReadyPct = 100; outReadyPct = 100; latMin = 1; latMax = 1; errBeat = -1;
    startBurst(20'h00010, 4);
    waitBurst(4, 200, to);
    checks++; if (to) $display("[TB] FAIL basic_timeout: got timeout expected done"); else passes++;
    checks++; if (arObs.size() !== 4) $display("[TB] FAIL basic_ar_count: got %0d expected 4", arObs.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ea;
      ea = 20'h00010 + AW'(i);
      checks++; if (i >= arObs.size() || arObs[i] !== ea) $display("[TB] FAIL basic_araddr[%0d]: got %h expected %h", i, arObs[i], ea); else passes++;
      checks++; if (i >= outObs.size() || outObs[i] !== memWord(ea)) $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, outObs[i], memWord(ea)); else passes++;
    end
    checks++; if (doneCount !== 1) $display("[TB] FAIL basic_done_pulses: got %0d expected 1", doneCount); else passes++;
    checks++; if (outCyc.size() == 4 && outCyc[3] - outCyc[0] !== 3) $display("[TB] FAIL basic_throughput: got %0d cycles expected 3", outCyc[3] - outCyc[0]); else passes++;
  endtask

  task automatic test_len_zero();
    clearObs();
    arReadyPct = 100; outReadyPct = 100;
    @(posedge clk);
    #1;
    start = 1'b1; baseAddr = 20'h00123; len = '0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL len0_busy_before: got %b expected 0", busy); else passes++;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b1) $display("[TB] FAIL len0_done: got %b expected 1", done); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL len0_busy: got %b expected 1", busy); else passes++;
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b0) $display("[TB] FAIL len0_done_after: got %b expected 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL len0_busy_after: got %b expected 0", busy); else passes++;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (arCount !== 0) $display("[TB] FAIL len0_ar_count: got %0d expected 0", arCount); else passes++;
    checks++; if (doneCount !== 1) $display("[TB] FAIL len0_done_pulses: got %0d expected 1", doneCount); else passes++;
  endtask

  task automatic test_wrap();
    bit to;
    logic [AW-1:0] expA[4];
    expA[0] = 20'hFFFFE; expA[1] = 20'hFFFFF; expA[2] = 20'h00000; expA[3] = 20'h00001;
    arReadyPct = 60; outReadyPct = 80; latMin = 1; latMax = 3; errBeat = -1;
    startBurst(20'hFFFFE, 4);
    waitBurst(4, 400, to);
    checks++; if (to) $display("[TB] FAIL wrap_timeout: got timeout expected done"); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= arObs.size() || arObs[i] !== expA[i]) $display("[TB] FAIL wrap_araddr[%0d]: got %h expected %h", i, arObs[i], expA[i]); else passes++;
      checks++; if (i >= outObs.size() || outObs[i] !== memWord(expA[i])) $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, outObs[i], memWord(expA[i])); else passes++;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [AW-1:0] b;
    b = AW'($urandom);
    arReadyPct = 100; outReadyPct = 0; latMin = 1; latMax = 1; errBeat = -1;
    startBurst(b, 8);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (arCount !== DEPTH) $display("[TB] FAIL bp_ar_stalled: got %0d expected %0d", arCount, DEPTH); else passes++;
    checks++; if (bus.axi_arvalid !== 1'b0) $display("[TB] FAIL bp_arvalid_low: got %b expected 0", bus.axi_arvalid); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL bp_busy: got %b expected 1", busy); else passes++;
    outReadyPct = 100;
    waitBurst(8, 400, to);
    checks++; if (to) $display("[TB] FAIL bp_timeout: got timeout expected done"); else passes++;
    checks++; if (outObs.size() !== 8) $display("[TB] FAIL bp_word_count: got %0d expected 8", outObs.size()); else passes++;
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] ea;
      ea = modelAddr(b, i);
      checks++; if (i >= outObs.size() || outObs[i] !== memWord(ea)) $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, outObs[i], memWord(ea)); else passes++;
    end
  endtask

  task automatic test_error();
    bit to;
    logic [AW-1:0] b;
    b = AW'($urandom);
    arReadyPct = 100; outReadyPct = 100; latMin = 1; latMax = 1; errBeat = 1;
    startBurst(b, 3);
    waitBurst(3, 200, to);
    checks++; if (to) $display("[TB] FAIL err_timeout: got timeout expected done"); else passes++;
    checks++; if (errAtDone !== 1'b1) $display("[TB] FAIL err_at_done: got %b expected 1", errAtDone); else passes++;
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] ea;
      ea = modelAddr(b, i);
      checks++; if (i >= outObs.size() || outObs[i] !== memWord(ea)) $display("[TB] FAIL err_data[%0d]: got %h expected %h", i, outObs[i], memWord(ea)); else passes++;
    end
    checks++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", err); else passes++;
    errBeat = -1;
    startBurst(b + 20'h100, 2);
    @(negedge clk);
    #1;
    checks++; if (err !== 1'b0) $display("[TB] FAIL err_cleared: got %b expected 0", err); else passes++;
    waitBurst(2, 200, to);
    checks++; if (to || errAtDone !== 1'b0) $display("[TB] FAIL err_clean_burst: got %b expected 0", errAtDone); else passes++;
  endtask

  task automatic test_reset_midflight();
    bit to;
    bit sawRready;
    int k;
    arReadyPct = 100; outReadyPct = 100; latMin = 8; latMax = 8; errBeat = -1;
    startBurst(20'h00040, 4);
    k = 0;
    while (arCount < 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++; if (arCount < 2) $display("[TB] FAIL rstmid_inflight: got %0d expected >=2", arCount); else passes++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({busy, done, err} !== 3'b000) $display("[TB] FAIL rstmid_status: got %b expected 000", {busy, done, err}); else passes++;
    checks++; if ({bus.axi_arvalid, bus.axi_rready, bus.out_valid} !== 3'b000) $display("[TB] FAIL rstmid_bus: got %b expected 000", {bus.axi_arvalid, bus.axi_rready, bus.out_valid}); else passes++;
    sawRready = 1'b0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (bus.axi_rready) sawRready = 1'b1;
    end
    checks++; if (sawRready !== 1'b0) $display("[TB] FAIL rstmid_late_r: got rready %b expected 0", sawRready); else passes++;
    flushResp = 1'b1;
    latMin = 1; latMax = 1;
    repeat (2) @(negedge clk);
    startBurst(20'h00020, 1);
    waitBurst(1, 200, to);
    checks++; if (to) $display("[TB] FAIL rstmid_timeout: got timeout expected done"); else passes++;
    checks++; if (arObs.size() < 1 || arObs[0] !== 20'h00020) $display("[TB] FAIL rstmid_araddr: got %h expected 00020", arObs[0]); else passes++;
    checks++; if (outObs.size() !== 1 || outObs[0] !== memWord(20'h00020)) $display("[TB] FAIL rstmid_data: got %h expected %h", outObs[0], memWord(20'h00020)); else passes++;
    checks++; if (doneCount !== 1) $display("[TB] FAIL rstmid_done: got %0d expected 1", doneCount); else passes++;
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] b;
      int n;
      b = AW'($urandom);
      n = int'($urandom_range(12, 1));
      arReadyPct = int'($urandom_range(100, 40));
      outReadyPct = int'($urandom_range(100, 30));
      latMin = 1;
      latMax = int'($urandom_range(4, 1));
      errBeat = -1;
      startBurst(b, n);
      waitBurst(n, 2000, to);
      checks++; if (to) $display("[TB] FAIL rand%0d_timeout: got timeout expected done", t); else passes++;
      checks++; if (arObs.size() !== n) $display("[TB] FAIL rand%0d_ar_count: got %0d expected %0d", t, arObs.size(), n); else passes++;
      for (int i = 0; i < n; i++) begin
        logic [AW-1:0] ea;
        ea = modelAddr(b, i);
        checks++; if (i >= arObs.size() || arObs[i] !== ea) $display("[TB] FAIL rand%0d_araddr[%0d]: got %h expected %h", t, i, arObs[i], ea); else passes++;
        checks++; if (i >= outObs.size() || outObs[i] !== memWord(ea)) $display("[TB] FAIL rand%0d_data[%0d]: got %h expected %h", t, i, outObs[i], memWord(ea)); else passes++;
      end
      checks++; if (doneCount !== 1 || errAtDone !== 1'b0) $display("[TB] FAIL rand%0d_done: got %0d/%b expected 1/0", t, doneCount, errAtDone); else passes++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    baseAddr = '0;
    len = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_backpressure();
    test_error();
    test_reset_midflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
